// File: rtl/pixel_hierarchy_if.sv
// Request/grant/event bundle between the pixel array and the two-level arbiter.
// The master drives the pixel requests; the slave returns grants, release pulses and event words.
interface pixel_hierarchy_if #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int POLARITY = 2,
    parameter int WIDTH    = $clog2(ROWS) + $clog2(COLS) + POLARITY
);
    logic [ROWS-1:0][COLS-1:0][POLARITY-1:0] req_i;
    logic [ROWS-1:0][COLS-1:0]               gnt_out_o;
    logic                                    grp_release_out_o;
    logic [WIDTH-1:0]                        data_out_o;

    modport master (
        output req_i,
        input  gnt_out_o,
        input  grp_release_out_o,
        input  data_out_o
    );

    modport slave (
        input  req_i,
        output gnt_out_o,
        output grp_release_out_o,
        output data_out_o
    );
endinterface

// File: rtl/pixel_hierarchy_top.sv
// Two-level event arbiter: round-robin over rows (as snapshot groups), lowest-first over columns,
// with a registered {row, col, polarity} event word for each grant.
module pixel_hierarchy_top #(
    parameter int  ROWS     = 8,
    parameter int  COLS     = 8,
    parameter int  POLARITY = 2,
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(COLS),
    localparam int WIDTH    = RW + CW + POLARITY
) (
    input  logic             clk_i,
    input  logic             reset_i,
    pixel_hierarchy_if.slave bus
);
    logic [ROWS-1:0][COLS-1:0] active;
    logic [ROWS-1:0]           row_any;

    genvar gi, gj;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                assign active[gi][gj] = |bus.req_i[gi][gj];
            end
            assign row_any[gi] = |active[gi];
        end
    endgenerate

    logic             locked_q, locked_d;
    logic [RW-1:0]    lock_row_q, lock_row_d;
    logic [COLS-1:0]  snap_q, snap_d;
    logic [RW-1:0]    rr_row_q, rr_row_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [RW-1:0]             probe_row;
    logic [RW-1:0]             sel_row;
    logic                      sel_found;
    logic [RW-1:0]             cur_row;
    logic [COLS-1:0]           cand_mask;
    logic [CW-1:0]             gnt_col;
    logic                      gnt_any;
    logic [COLS-1:0]           gnt_onehot;
    logic [COLS-1:0]           remaining;
    logic                      release_int;
    logic [ROWS-1:0][COLS-1:0] gnt_vec;

    always_comb begin
        probe_row = rr_row_q;
        sel_row   = rr_row_q;
        sel_found = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            probe_row = rr_row_q + RW'(i);
            if (!sel_found && row_any[probe_row]) begin
                sel_found = 1'b1;
                sel_row   = probe_row;
            end
        end

        // A locked group only serves pixels captured in its snapshot that are still requesting.
        cur_row   = locked_q ? lock_row_q : sel_row;
        cand_mask = locked_q ? (snap_q & active[lock_row_q]) : active[sel_row];

        gnt_col = '0;
        gnt_any = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (!gnt_any && cand_mask[c]) begin
                gnt_any = 1'b1;
                gnt_col = CW'(c);
            end
        end
        gnt_onehot = gnt_any ? (COLS'(1) << gnt_col) : '0;
        remaining  = cand_mask & ~gnt_onehot;

        locked_d    = locked_q;
        lock_row_d  = lock_row_q;
        snap_d      = snap_q;
        rr_row_d    = rr_row_q;
        release_int = 1'b0;
        if (locked_q) begin
            if (remaining == '0) begin
                release_int = 1'b1;
                locked_d    = 1'b0;
                snap_d      = '0;
                rr_row_d    = lock_row_q + RW'(1);
            end else begin
                snap_d = snap_q & ~gnt_onehot;
            end
        end else if (gnt_any) begin
            if (remaining != '0) begin
                locked_d   = 1'b1;
                lock_row_d = sel_row;
                snap_d     = remaining;
            end else begin
                release_int = 1'b1;
                rr_row_d    = sel_row + RW'(1);
            end
        end

        gnt_vec = '0;
        if (gnt_any && reset_i) begin
            gnt_vec[cur_row] = gnt_onehot;
        end
        data_d = {cur_row, gnt_col, bus.req_i[cur_row][gnt_col]};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            locked_q   <= 1'b0;
            lock_row_q <= '0;
            snap_q     <= '0;
            rr_row_q   <= '0;
            data_q     <= '0;
        end else begin
            locked_q   <= locked_d;
            lock_row_q <= lock_row_d;
            snap_q     <= snap_d;
            rr_row_q   <= rr_row_d;
            if (gnt_any) begin
                data_q <= data_d;
            end
        end
    end

    assign bus.gnt_out_o         = gnt_vec;
    assign bus.grp_release_out_o = release_int & reset_i;
    assign bus.data_out_o        = data_q;
endmodule

// File: tb/tb_pixel_hierarchy_top.sv
// Directed and random-fill checks of the two-level pixel arbiter at 8x8, 2-bit polarity.
module tb_pixel_hierarchy_top;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    pixel_hierarchy_if #(.ROWS(8), .COLS(8), .POLARITY(2)) bus ();

    pixel_hierarchy_top #(.ROWS(8), .COLS(8), .POLARITY(2)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] gbit(input int r, input int c);
        logic [63:0] b;
        b = 64'd1;
        return b << (r * 8 + c);
    endfunction

    function automatic logic [7:0] enc(input logic [2:0] r, input logic [2:0] c, input logic [1:0] p);
        return {r, c, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Settle combinational outputs after input changes, then check grant and release.
    task automatic expect_cycle(input string tag, input logic [63:0] exp_gnt, input logic exp_rel);
        #1;
        $display("[%0t] %s gnt=%016h rel=%0b", $time, tag, bus.gnt_out_o, bus.grp_release_out_o);
        check_eq({tag, "_gnt"}, bus.gnt_out_o, exp_gnt);
        check_eq({tag, "_rel"}, {63'd0, bus.grp_release_out_o}, {63'd0, exp_rel});
    endtask

    task automatic expect_data(input string tag, input logic [7:0] exp);
        $display("[%0t] %s data=%02h", $time, tag, bus.data_out_o);
        check_eq({tag, "_data"}, {56'd0, bus.data_out_o}, {56'd0, exp});
    endtask

    initial begin
        logic [1:0] model [8][8];
        int         nz;
        int         grants;
        int         gr, gc;

        rst_n     = 1'b0;
        bus.req_i = '0;

        // Reset holds outputs low even with every pixel requesting.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                bus.req_i[r][c] = 2'b01;
        tick();
        tick();
        expect_cycle("rst_hold", 64'd0, 1'b0);
        expect_data("rst_hold", 8'h00);
        rst_n = 1'b1;
        expect_cycle("rst_first", gbit(0, 0), 1'b0);
        tick();
        expect_data("rst_first", 8'h01);

        // Abandon the locked group with a mid-group reset.
        rst_n     = 1'b0;
        bus.req_i = '0;
        tick();
        expect_data("rst_mid", 8'h00);
        rst_n = 1'b1;
        expect_cycle("idle", 64'd0, 1'b0);

        // Single pixel.
        bus.req_i[3][5] = 2'b10;
        expect_cycle("single", gbit(3, 5), 1'b1);
        tick();
        bus.req_i[3][5] = 2'b00;
        expect_data("single", 8'b011_101_10);
        expect_cycle("single_after", 64'd0, 1'b0);

        // Group order within row 2.
        bus.req_i[2][1] = 2'b10;
        bus.req_i[2][4] = 2'b10;
        bus.req_i[2][6] = 2'b10;
        expect_cycle("grp1", gbit(2, 1), 1'b0);
        tick();
        bus.req_i[2][1] = 2'b00;
        expect_data("grp1", 8'h46);
        expect_cycle("grp2", gbit(2, 4), 1'b0);
        tick();
        bus.req_i[2][4] = 2'b00;
        expect_data("grp2", 8'h52);
        expect_cycle("grp3", gbit(2, 6), 1'b1);
        tick();
        bus.req_i[2][6] = 2'b00;
        expect_data("grp3", 8'h5A);

        // Row round-robin and wrap (pointer is at row 3 here).
        bus.req_i[0][2] = 2'b01;
        bus.req_i[7][3] = 2'b01;
        expect_cycle("rr_a", gbit(7, 3), 1'b1);
        tick();
        bus.req_i[7][3] = 2'b00;
        expect_data("rr_a", 8'hED);
        expect_cycle("rr_b", gbit(0, 2), 1'b1);
        tick();
        expect_data("rr_b", 8'h09);
        bus.req_i[7][3] = 2'b01;
        expect_cycle("rr_c", gbit(7, 3), 1'b1);
        tick();
        bus.req_i[7][3] = 2'b00;
        expect_data("rr_c", 8'hED);
        expect_cycle("rr_d", gbit(0, 2), 1'b1);
        tick();
        bus.req_i[0][2] = 2'b00;
        expect_data("rr_d", 8'h09);

        // Late arrival in a locked row is deferred to the next group.
        bus.req_i[1][0] = 2'b01;
        bus.req_i[1][3] = 2'b01;
        expect_cycle("late1", gbit(1, 0), 1'b0);
        tick();
        bus.req_i[1][0] = 2'b00;
        bus.req_i[1][2] = 2'b01;
        expect_data("late1", 8'h21);
        expect_cycle("late2", gbit(1, 3), 1'b1);
        tick();
        bus.req_i[1][3] = 2'b00;
        expect_data("late2", 8'h2D);
        expect_cycle("late3", gbit(1, 2), 1'b1);
        tick();
        bus.req_i[1][2] = 2'b00;
        expect_data("late3", 8'h29);

        // Empty release: the snapshot withdraws; polarity 2'b11 carried unchanged.
        bus.req_i[5][1] = 2'b11;
        bus.req_i[5][2] = 2'b11;
        expect_cycle("empty1", gbit(5, 1), 1'b0);
        tick();
        bus.req_i[5][1] = 2'b00;
        bus.req_i[5][2] = 2'b00;
        expect_data("empty1", 8'hA7);
        expect_cycle("empty2", 64'd0, 1'b1);
        tick();
        expect_data("empty_hold", 8'hA7);
        expect_cycle("empty3", 64'd0, 1'b0);

        // Random fill; each request is cleared once granted.
        nz = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                model[r][c]     = 2'($urandom % 3);
                bus.req_i[r][c] = model[r][c];
                if (model[r][c] != 2'b00) nz++;
            end
        grants = 0;
        for (int cyc = 0; cyc < 100 && bus.req_i != '0; cyc++) begin
            #1;
            check_eq("rnd_onehot", 64'($countones(bus.gnt_out_o)), 64'd1);
            gr = -1;
            gc = -1;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (bus.gnt_out_o[r][c]) begin
                        gr = r;
                        gc = c;
                    end
            if (gr >= 0) begin
                $display("[%0t] rnd grant row=%0d col=%0d pol=%0b", $time, gr, gc, model[gr][gc]);
                check_eq("rnd_req_nz", {63'd0, model[gr][gc] != 2'b00}, 64'd1);
                tick();
                expect_data("rnd", enc(3'(gr), 3'(gc), model[gr][gc]));
                grants++;
                bus.req_i[gr][gc] = 2'b00;
                model[gr][gc]     = 2'b00;
            end else begin
                tick();
            end
        end
        check_eq("rnd_count", 64'(grants), 64'(nz));
        check_eq("rnd_left", {63'd0, bus.req_i != '0}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
